// File: rtl/binarize_ctrl.sv
// Frame-synchronous controller: calibration frames, then binary display; offset shadowed and committed on frame start.
// All outputs registered; changes land on the cycle after vsync falls.
module binarize_ctrl #(
    parameter int          CAL_FRAMES  = 2,
    parameter logic [7:0]  OFFSET_DEF  = 8'h20,
    parameter logic [7:0]  OFFSET_STEP = 8'h04,
    parameter int          FCNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vsync,
    input  logic              req_toggle,
    input  logic              off_inc,
    input  logic              off_dec,
    output logic              calib,
    output logic              bin_en,
    output logic [7:0]        offset,
    output logic [1:0]        state,
    output logic              pending,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_CAL = 2'd1;
    localparam logic [1:0] S_ON  = 2'd2;

    logic       vsync_d;
    logic       fs;
    logic       req_eff;
    logic [7:0] shadow;
    logic [7:0] shadow_nxt;
    logic [8:0] sum9;
    logic [3:0] cal_cnt;

    assign fs      = vsync_d & ~vsync;
    assign req_eff = pending ^ req_toggle;

    // Simultaneous inc and dec cancel; both directions saturate.
    always_comb begin
        sum9       = {1'b0, shadow} + {1'b0, OFFSET_STEP};
        shadow_nxt = shadow;
        if (off_inc && !off_dec)
            shadow_nxt = sum9[8] ? 8'hFF : sum9[7:0];
        else if (off_dec && !off_inc)
            shadow_nxt = (shadow < OFFSET_STEP) ? 8'h00 : (shadow - OFFSET_STEP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_d   <= 1'b0;
            shadow    <= OFFSET_DEF;
            offset    <= OFFSET_DEF;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_d <= vsync;
            shadow  <= shadow_nxt;
            if (fs) begin
                offset    <= shadow_nxt;
                pending   <= 1'b0;
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end else begin
                pending   <= req_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_OFF;
            calib   <= 1'b0;
            bin_en  <= 1'b0;
            cal_cnt <= 4'd0;
        end else if (fs) begin
            case (state)
                S_OFF: begin
                    if (req_eff) begin
                        state   <= S_CAL;
                        calib   <= 1'b1;
                        cal_cnt <= 4'(CAL_FRAMES - 1);
                    end
                end
                S_CAL: begin
                    // An abort request wins over calibration completing on the same boundary.
                    if (req_eff) begin
                        state <= S_OFF;
                        calib <= 1'b0;
                    end else if (cal_cnt == 4'd0) begin
                        state  <= S_ON;
                        calib  <= 1'b0;
                        bin_en <= 1'b1;
                    end else begin
                        cal_cnt <= cal_cnt - 4'd1;
                    end
                end
                S_ON: begin
                    if (req_eff) begin
                        state  <= S_OFF;
                        bin_en <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_OFF;
                    calib  <= 1'b0;
                    bin_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binarize_ctrl.sv
// Directed bench for binarize_ctrl: table of per-frame vectors plus hand sequences for boundary cases.
module tb_binarize_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vsync = 1'b0, req_toggle = 1'b0, off_inc = 1'b0, off_dec = 1'b0;
    logic        calib, bin_en, pending;
    logic [7:0]  offset;
    logic [1:0]  state;
    logic [15:0] frame_cnt;

    logic        vsync2 = 1'b0, dec2 = 1'b0;
    logic        calib2, bin_en2, pending2;
    logic [7:0]  offset2;
    logic [1:0]  state2;
    logic [15:0] frame_cnt2;

    always #5 clk = ~clk;

    binarize_ctrl dut (
        .clk(clk), .rstn(rstn), .vsync(vsync), .req_toggle(req_toggle),
        .off_inc(off_inc), .off_dec(off_dec), .calib(calib), .bin_en(bin_en),
        .offset(offset), .state(state), .pending(pending), .frame_cnt(frame_cnt)
    );

    binarize_ctrl #(.OFFSET_DEF(8'h02)) dut2 (
        .clk(clk), .rstn(rstn), .vsync(vsync2), .req_toggle(1'b0),
        .off_inc(1'b0), .off_dec(dec2), .calib(calib2), .bin_en(bin_en2),
        .offset(offset2), .state(state2), .pending(pending2), .frame_cnt(frame_cnt2)
    );

    int checks = 0;
    int passed = 0;
    int both_cnt = 0;
    int bin_cycles = 0;
    int exp_fc = 0;

    always @(negedge clk) begin
        if (calib && bin_en) both_cnt++;
        if (bin_en) bin_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic pulse(input logic r, input logic i, input logic d);
        req_toggle = r; off_inc = i; off_dec = d;
        @(negedge clk);
        req_toggle = 1'b0; off_inc = 1'b0; off_dec = 1'b0;
        @(negedge clk);
    endtask

    // One vsync high/low cycle; optional req/inc driven on the falling-edge cycle itself.
    task automatic frame(input logic r, input logic i);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0; req_toggle = r; off_inc = i;
        @(negedge clk);
        req_toggle = 1'b0; off_inc = 1'b0;
        exp_fc++;
    endtask

    typedef struct {
        logic [1:0] n_req;
        logic [3:0] n_inc;
        logic [3:0] n_dec;
        logic       both;
        logic       exp_pend;
        logic [7:0] exp_pre_off;
        logic [1:0] exp_state;
        logic       exp_calib;
        logic       exp_bin;
        logic [7:0] exp_off;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int bc0;
        tbl[0]  = '{2'd1, 4'd0,  4'd0,  1'b0, 1'b1, 8'h20, 2'd1, 1'b1, 1'b0, 8'h20};
        tbl[1]  = '{2'd0, 4'd0,  4'd0,  1'b0, 1'b0, 8'h20, 2'd1, 1'b1, 1'b0, 8'h20};
        tbl[2]  = '{2'd0, 4'd0,  4'd0,  1'b0, 1'b0, 8'h20, 2'd2, 1'b0, 1'b1, 8'h20};
        tbl[3]  = '{2'd2, 4'd0,  4'd0,  1'b0, 1'b0, 8'h20, 2'd2, 1'b0, 1'b1, 8'h20};
        tbl[4]  = '{2'd0, 4'd9,  4'd0,  1'b0, 1'b0, 8'h20, 2'd2, 1'b0, 1'b1, 8'h44};
        tbl[5]  = '{2'd0, 4'd15, 4'd0,  1'b0, 1'b0, 8'h44, 2'd2, 1'b0, 1'b1, 8'h80};
        tbl[6]  = '{2'd0, 4'd15, 4'd0,  1'b0, 1'b0, 8'h80, 2'd2, 1'b0, 1'b1, 8'hBC};
        tbl[7]  = '{2'd0, 4'd15, 4'd0,  1'b0, 1'b0, 8'hBC, 2'd2, 1'b0, 1'b1, 8'hF8};
        tbl[8]  = '{2'd0, 4'd2,  4'd0,  1'b0, 1'b0, 8'hF8, 2'd2, 1'b0, 1'b1, 8'hFF};
        tbl[9]  = '{2'd0, 4'd0,  4'd0,  1'b1, 1'b0, 8'hFF, 2'd2, 1'b0, 1'b1, 8'hFF};
        tbl[10] = '{2'd0, 4'd0,  4'd15, 1'b0, 1'b0, 8'hFF, 2'd2, 1'b0, 1'b1, 8'hC3};
        tbl[11] = '{2'd0, 4'd0,  4'd15, 1'b0, 1'b0, 8'hC3, 2'd2, 1'b0, 1'b1, 8'h87};
        tbl[12] = '{2'd0, 4'd0,  4'd15, 1'b0, 1'b0, 8'h87, 2'd2, 1'b0, 1'b1, 8'h4B};
        tbl[13] = '{2'd0, 4'd0,  4'd15, 1'b0, 1'b0, 8'h4B, 2'd2, 1'b0, 1'b1, 8'h0F};
        tbl[14] = '{2'd0, 4'd0,  4'd5,  1'b0, 1'b0, 8'h0F, 2'd2, 1'b0, 1'b1, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_calib", 32'(calib), 32'd0);
        chk("rst_bin_en", 32'(bin_en), 32'd0);
        chk("rst_offset", 32'(offset), 32'h20);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int f = 1; f <= 3; f++) begin
            frame(1'b0, 1'b0);
            repeat (10) @(negedge clk);
            chk("idle_frame_cnt", 32'(frame_cnt), 32'(f));
            chk("idle_state", 32'(state), 32'd0);
        end

        for (int v = 0; v < 15; v++) begin
            for (int k = 0; k < int'(tbl[v].n_req); k++) pulse(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < int'(tbl[v].n_inc); k++) pulse(1'b0, 1'b1, 1'b0);
            for (int k = 0; k < int'(tbl[v].n_dec); k++) pulse(1'b0, 1'b0, 1'b1);
            if (tbl[v].both) for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 1'b1);
            chk($sformatf("v%0d_pre_pending", v), 32'(pending), 32'(tbl[v].exp_pend));
            chk($sformatf("v%0d_pre_offset", v), 32'(offset), 32'(tbl[v].exp_pre_off));
            frame(1'b0, 1'b0);
            chk($sformatf("v%0d_state", v), 32'(state), 32'(tbl[v].exp_state));
            chk($sformatf("v%0d_calib", v), 32'(calib), 32'(tbl[v].exp_calib));
            chk($sformatf("v%0d_bin_en", v), 32'(bin_en), 32'(tbl[v].exp_bin));
            chk($sformatf("v%0d_offset", v), 32'(offset), 32'(tbl[v].exp_off));
            chk($sformatf("v%0d_pending", v), 32'(pending), 32'd0);
            chk($sformatf("v%0d_frame_cnt", v), 32'(frame_cnt), 32'(exp_fc));
            repeat (4) @(negedge clk);
        end

        // Toggle and inc coincident with the falling edge act on that boundary.
        frame(1'b1, 1'b1);
        chk("coinc_state", 32'(state), 32'd0);
        chk("coinc_bin_en", 32'(bin_en), 32'd0);
        chk("coinc_pending", 32'(pending), 32'd0);
        chk("coinc_offset", 32'(offset), 32'h04);

        // Abort during calibration.
        bc0 = bin_cycles;
        pulse(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        chk("abort_enter_cal", 32'(state), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_calib", 32'(calib), 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_no_bin_en", 32'(bin_cycles), 32'(bc0));

        // No vsync activity: everything holds.
        pulse(1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        chk("freeze_pending", 32'(pending), 32'd1);
        chk("freeze_state", 32'(state), 32'd0);
        chk("freeze_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        frame(1'b0, 1'b0);
        chk("freeze_then_cal", 32'(state), 32'd1);
        pulse(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-calibration.
        #2 rstn = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_calib", 32'(calib), 32'd0);
        chk("arst_offset", 32'(offset), 32'h20);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_fc = 0;
        repeat (5) @(negedge clk);
        chk("post_rst_no_fs", 32'(frame_cnt), 32'd0);
        frame(1'b0, 1'b0);
        chk("post_rst_frame", 32'(frame_cnt), 32'd1);
        chk("post_rst_offset", 32'(offset), 32'h20);

        // Decrement saturation from 8'h02 on the second instance.
        chk("dut2_pre_offset", 32'(offset2), 32'h02);
        dec2 = 1'b1;
        @(negedge clk);
        dec2 = 1'b0;
        vsync2 = 1'b1;
        repeat (3) @(negedge clk);
        vsync2 = 1'b0;
        @(negedge clk);
        chk("dut2_dec_sat", 32'(offset2), 32'h00);

        chk("calib_bin_en_exclusive", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
